// File: rtl/dma_io_ingest.sv
// rtl/dma_io_ingest.sv - DMA channel moving words from the buffered I/O device into memory
module dma_io_ingest #(
  parameter int         ADDR_W        = 32,
  parameter int         DATA_W        = 32,
  parameter int         MAX_LEN       = 31,
  parameter logic [8:0] IO_BASE_INDEX = 9'h1C0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  input  logic              gpio_req,
  output logic              io_ack,
  output logic              io_write,
  output logic [8:0]        io_index,
  input  logic [DATA_W-1:0] io_data,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done_irq
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] dst_base, cur_addr;
  logic [LEN_W-1:0]  length, word_cnt, cnt_next, len_clamped;
  logic              en, irq_en, done, abort_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              busy, ctl_wr, abort, accept, len_hit;

  assign busy     = (state != S_IDLE);
  assign ctl_wr   = cfg_we && (cfg_sel == 2'd2);
  // Writing en=0 mid-transfer stops acceptance in that very cycle.
  assign abort    = ctl_wr && !cfg_wdata[0] && busy;
  assign accept   = (state == S_XFER) && gpio_req && bus_grant && !abort;
  assign cnt_next = word_cnt + LEN_W'(1);
  assign len_hit  = accept && (length != '0) && (cnt_next == length);

  assign len_clamped = (cfg_wdata > 32'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_wdata[LEN_W-1:0];

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (en && gpio_req) state_n = S_REQ;
      S_REQ: begin
        if (bus_grant)      state_n = S_XFER;
        else if (!gpio_req) state_n = S_IDLE;
      end
      S_XFER: begin
        if (len_hit || !gpio_req) state_n = S_FLUSH;
        else if (!bus_grant)      state_n = S_REQ;
      end
      S_FLUSH: state_n = abort_q ? S_IDLE : S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // An abort holds the bus one more cycle only when a write is still on it.
    if (abort) state_n = mem_we_q ? S_FLUSH : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      dst_base    <= '0;
      length      <= '0;
      en          <= 1'b0;
      irq_en      <= 1'b0;
      done        <= 1'b0;
      cur_addr    <= '0;
      word_cnt    <= '0;
      abort_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state <= state_n;
      if (cfg_we && !busy && cfg_sel == 2'd0) dst_base <= ADDR_W'(cfg_wdata);
      if (cfg_we && !busy && cfg_sel == 2'd1) length <= len_clamped;
      if (ctl_wr) begin
        en     <= cfg_wdata[0];
        irq_en <= cfg_wdata[1];
        done   <= 1'b0;
      end else if (state == S_DONE) begin
        en   <= 1'b0;
        done <= 1'b1;
      end
      if (state == S_IDLE && state_n == S_REQ) begin
        cur_addr <= dst_base;
        word_cnt <= '0;
      end else if (accept) begin
        cur_addr <= cur_addr + ADDR_W'(1);
        word_cnt <= cnt_next;
      end
      if (abort)
        abort_q <= 1'b1;
      else if (state == S_FLUSH || state == S_IDLE)
        abort_q <= 1'b0;
      mem_we_q <= accept;
      if (accept) begin
        mem_addr_q  <= cur_addr;
        mem_wdata_q <= io_data;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_sel)
      2'd0: cfg_rdata = 32'(dst_base);
      2'd1: cfg_rdata = 32'(length);
      2'd2: cfg_rdata = {30'd0, irq_en, en};
      default: cfg_rdata = (32'(word_cnt) << 8) | {30'd0, done, busy};
    endcase
  end

  assign bus_req   = (state == S_REQ) || (state == S_XFER) || (state == S_FLUSH);
  assign io_ack    = (state == S_XFER) && !abort;
  assign io_write  = 1'b0;
  assign io_index  = (state == S_XFER) ? IO_BASE_INDEX : 9'd0;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done_irq  = (state == S_DONE) && irq_en;

endmodule

// File: tb/tb_dma_io_ingest.sv
// tb/tb_dma_io_ingest.sv - randomized bench for dma_io_ingest with device, CPU and memory models
module tb_dma_io_ingest;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        gpio_req, io_ack, io_write;
  logic [8:0]  io_index;
  logic [31:0] io_data;
  logic        bus_req, bus_grant;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        done_irq;

  dma_io_ingest dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .gpio_req(gpio_req), .io_ack(io_ack), .io_write(io_write),
    .io_index(io_index), .io_data(io_data), .bus_req(bus_req), .bus_grant(bus_grant),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Device buffer, CPU grant policy and expected memory image.
  logic [31:0] dev_buf [32];
  int          dev_ptr = 0;
  int          dev_len = 0;
  int          gp = 100;
  int          irq_seen = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: called and returns at a falling edge.
  task automatic tick();
    logic acc;
    if (mem_we === 1'b1) begin
      check("we_expected", 64'(exp_addr.size() > 0), 64'd1);
      if (exp_addr.size() > 0) begin
        check("mem_addr", mem_addr, exp_addr.pop_front());
        check("mem_wdata", mem_wdata, exp_data.pop_front());
      end
    end
    if (done_irq === 1'b1) irq_seen++;
    gpio_req  = (dev_ptr < dev_len);
    io_data   = (dev_ptr < dev_len) ? dev_buf[dev_ptr] : 32'd0;
    bus_grant = (bus_req === 1'b1) && ($urandom_range(0, 99) < gp);
    #1;
    acc = (io_ack === 1'b1) && gpio_req && bus_grant && !rst;
    @(posedge clk);
    if (acc) dev_ptr++;
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
    tick();
    cfg_we = 1'b0; cfg_sel = 2'd3;
  endtask

  task automatic cfg_read(input logic [1:0] sel, output logic [31:0] v);
    cfg_sel = sel;
    #1 v = cfg_rdata;
    cfg_sel = 2'd3;
  endtask

  task automatic fill_dev(input int k, input bit fixed);
    for (int i = 0; i < 32; i++) dev_buf[i] = fixed ? 32'(i + 10) : $urandom;
    dev_ptr = 0;
    dev_len = k;
  endtask

  task automatic run_transfer(input logic [31:0] base, input int len, input int k,
                              input bit irq, input int g, input bit fixed);
    logic [31:0] v;
    int exp_len, n, cyc;
    fill_dev(k, fixed);
    gp = g;
    cfg_write(2'd0, base);
    cfg_write(2'd1, 32'(len));
    cfg_read(2'd1, v);
    exp_len = (len > 31) ? 31 : len;
    check("len_readback", v, 64'(exp_len));
    n = (exp_len == 0 || k < exp_len) ? k : exp_len;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(base + 32'(i));
      exp_data.push_back(dev_buf[i]);
    end
    irq_seen = 0;
    cfg_write(2'd2, {30'd0, irq, 1'b1});
    cyc = 0;
    while (cyc < 600) begin
      tick();
      cyc++;
      cfg_read(2'd3, v);
      if (!v[0] && exp_addr.size() == 0) break;
    end
    check("xfer_in_time", 64'(cyc < 600), 64'd1);
    repeat (3) tick();
    check("writes_left", 64'(exp_addr.size()), 64'd0);
    check("irq_count", 64'(irq_seen), 64'(irq));
    cfg_read(2'd3, v);
    check("status", v, 64'((n << 8) | 2));
    cfg_read(2'd2, v);
    check("ctl_en_cleared", v, 64'({irq, 1'b0}));
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    logic [31:0] v;
    int cyc;
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd3; cfg_wdata = '0;
    gpio_req = 1'b0; bus_grant = 1'b0; io_data = '0;
    @(negedge clk);
    repeat (2) tick();
    check("rst_outs", {bus_req, io_ack, io_write, io_index, mem_we, done_irq}, 64'd0);
    cfg_read(2'd3, v);
    check("rst_status", v, 64'd0);
    rst = 1'b0;
    tick();

    run_transfer(32'h100, 3, 3, 1'b1, 100, 1'b1);
    run_transfer(32'h200, 0, 5, 1'b0, 100, 1'b0);
    run_transfer(32'h300, 4, 8, 1'b1, 50, 1'b0);
    run_transfer(32'hFFFF_FFFF, 2, 5, 1'b1, 70, 1'b0);

    for (int it = 0; it < 14; it++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      run_transfer(b, $urandom_range(0, 40), $urandom_range(1, 31), 1'($urandom_range(0, 1)),
                   $urandom_range(30, 100), 1'b0);
    end

    // Abort after two words, length clamped from 40.
    fill_dev(31, 1'b0);
    gp = 100;
    cfg_write(2'd0, 32'h400);
    cfg_write(2'd1, 32'd40);
    cfg_read(2'd1, v);
    check("abort_len_clamp", v, 64'd31);
    for (int i = 0; i < 2; i++) begin
      exp_addr.push_back(32'h400 + 32'(i));
      exp_data.push_back(dev_buf[i]);
    end
    irq_seen = 0;
    cfg_write(2'd2, 32'd3);
    cyc = 0;
    while (dev_ptr < 2 && cyc < 100) begin tick(); cyc++; end
    check("abort_reach", 64'(dev_ptr), 64'd2);
    cfg_write(2'd2, 32'd2);
    repeat (5) tick();
    check("abort_writes_left", 64'(exp_addr.size()), 64'd0);
    check("abort_irq", 64'(irq_seen), 64'd0);
    cfg_read(2'd3, v);
    check("abort_status", v, 64'h200);
    exp_addr.delete();
    exp_data.delete();

    // Reset in the middle of a transfer.
    fill_dev(20, 1'b0);
    cfg_write(2'd0, 32'h500);
    cfg_write(2'd1, 32'd10);
    exp_addr.push_back(32'h500);
    exp_data.push_back(dev_buf[0]);
    cfg_write(2'd2, 32'd3);
    cyc = 0;
    while (dev_ptr < 1 && cyc < 100) begin tick(); cyc++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outs", {bus_req, io_ack, io_write, io_index, mem_we, done_irq}, 64'd0);
    check("midrst_mem", {mem_addr, mem_wdata}, 64'd0);
    cfg_read(2'd3, v);
    check("midrst_status", v, 64'd0);
    cfg_read(2'd0, v);
    check("midrst_base", v, 64'd0);
    repeat (6) tick();
    check("midrst_writes_left", 64'(exp_addr.size()), 64'd0);
    check("midrst_idle_req", 64'(bus_req), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
